// File: rtl/warp_inst_fetch.sv
// Kernel instruction fetcher: word reads base+4*i into an in-order show-ahead FIFO; response-to-inst_valid 1 cycle.
// Requests are throttled by outstanding+FIFO credits, so memory responses are never backpressured.

module warp_inst_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != DEPTH_L) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
endmodule

module warp_inst_fetch #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int COUNT_WIDTH     = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic [ADDR_WIDTH-1:0]         start_base_addr_i,
  input  logic [COUNT_WIDTH-1:0]        start_count_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  output logic                          mem_req_write_o,
  output logic [DATA_WIDTH-1:0]         mem_req_data_o,
  input  logic                          mem_resp_valid_i,
  output logic                          mem_resp_ready_o,
  input  logic [DATA_WIDTH-1:0]         mem_resp_data_i,
  output logic                          inst_valid_o,
  input  logic                          inst_ready_i,
  output logic [DATA_WIDTH-1:0]         inst_data_o,
  output logic [ADDR_WIDTH-1:0]         inst_pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_FETCH      = 2'd1;
  localparam logic [1:0] ST_ABORT_WAIT = 2'd2;

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OSW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW  = ((FCW > OSW) ? FCW : OSW) + 1;
  localparam logic [SW-1:0]  DEPTH_L  = SW'(FIFO_DEPTH);
  localparam logic [OSW-1:0] MAX_OS_L = OSW'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dat;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [1:0]             state_q,    state_d;
  logic [ADDR_WIDTH-1:0]  base_q,     base_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;
  logic [COUNT_WIDTH-1:0] issued_q,   issued_d;
  logic [COUNT_WIDTH-1:0] received_q, received_d;
  logic [OSW-1:0]         outst_q,    outst_d;
  logic                   done_q,     done_d;
  logic                   error_q,    error_d;

  logic           start_rdy;
  logic           start_fire;
  logic           req_vld;
  logic           req_fire;
  logic           resp_take;
  logic           push;
  logic           pop;
  logic           last_push;
  logic           inst_vld;
  logic [SW-1:0]  credit_sum;
  logic [FCW-1:0] fifo_cnt;
  entry_t         push_ent;
  entry_t         head_ent;

  // Every in-flight read already owns a FIFO slot, so a response always has room.
  assign credit_sum = SW'(outst_q) + SW'(fifo_cnt);
  assign req_vld    = rst_n_i && (state_q == ST_FETCH) && !abort_i &&
                      (issued_q < count_q) && (outst_q < MAX_OS_L) && (credit_sum < DEPTH_L);
  assign req_fire   = req_vld && mem_req_ready_i;

  // Responses with nothing in flight are strays and are dropped.
  assign resp_take  = mem_resp_valid_i && (outst_q != '0);
  assign push       = resp_take && (state_q == ST_FETCH) && !abort_i;
  assign last_push  = push && ((received_q + COUNT_WIDTH'(1)) == count_q);

  assign inst_vld   = rst_n_i && (fifo_cnt != '0);
  assign pop        = inst_vld && inst_ready_i && !abort_i;

  assign start_rdy  = rst_n_i && (state_q == ST_IDLE) && (fifo_cnt == '0) && !abort_i;
  assign start_fire = start_valid_i && start_rdy;

  assign push_ent.dat = mem_resp_data_i;
  assign push_ent.pc  = base_q + (ADDR_WIDTH'(received_q) << 2);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;
    done_d     = 1'b0;
    error_d    = 1'b0;

    if (req_fire) issued_d   = issued_q + COUNT_WIDTH'(1);
    if (push)     received_d = received_q + COUNT_WIDTH'(1);

    case ({req_fire, resp_take})
      2'b10:   outst_d = outst_q + OSW'(1);
      2'b01:   outst_d = outst_q - OSW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_fire) begin
          if (start_base_addr_i[1:0] != 2'b00) begin
            error_d = 1'b1;
          end else if (start_count_i == '0) begin
            done_d = 1'b1;
          end else begin
            base_d     = start_base_addr_i;
            count_d    = start_count_i;
            issued_d   = '0;
            received_d = '0;
            state_d    = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          state_d = (outst_d != '0) ? ST_ABORT_WAIT : ST_IDLE;
        end else if (last_push) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_ABORT_WAIT: begin
        if (outst_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      received_q <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  warp_inst_fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (abort_i),
    .push_i     (push),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .count_o    (fifo_cnt)
  );

  assign start_ready_o    = start_rdy;
  assign busy_o           = rst_n_i && (state_q != ST_IDLE);
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign mem_req_valid_o  = req_vld;
  assign mem_req_addr_o   = base_q + (ADDR_WIDTH'(issued_q) << 2);
  assign mem_req_write_o  = 1'b0;
  assign mem_req_data_o   = '0;
  assign mem_resp_ready_o = 1'b1;
  assign inst_valid_o     = inst_vld;
  assign inst_data_o      = head_ent.dat;
  assign inst_pc_o        = head_ent.pc;
  assign fifo_count_o     = fifo_cnt;
endmodule

// File: tb/tb_warp_inst_fetch.sv
// Directed bench for warp_inst_fetch: a latency/ready-configurable memory model plus per-scenario tasks.
module tb_warp_inst_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start_valid, abort, inst_ready, mem_req_ready, mem_resp_valid;
  logic [31:0] start_base_addr, mem_resp_data;
  logic [15:0] start_count;
  logic        start_ready, busy, done, error, mem_req_valid, mem_req_write, mem_resp_ready, inst_valid;
  logic [31:0] mem_req_addr, mem_req_data, inst_data, inst_pc;
  logic [4:0]  fifo_count;

  always #5 clk = ~clk;

  warp_inst_fetch dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .start_valid_i(start_valid), .start_ready_o(start_ready),
    .start_base_addr_i(start_base_addr), .start_count_i(start_count),
    .abort_i(abort), .busy_o(busy), .done_o(done), .error_o(error),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_write_o(mem_req_write), .mem_req_data_o(mem_req_data),
    .mem_resp_valid_i(mem_resp_valid), .mem_resp_ready_o(mem_resp_ready), .mem_resp_data_i(mem_resp_data),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready),
    .inst_data_o(inst_data), .inst_pc_o(inst_pc), .fifo_count_o(fifo_count)
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          mem_lat = 1;
  int          rdy_mode = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  int          stall_seen, stall_viol, max_pend, done_cnt, err_cnt;
  logic [31:0] req_log [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_dat [$];
  pend_t       pending [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    req_log.delete(); got_pc.delete(); got_dat.delete();
    stall_seen = 0; stall_viol = 0; max_pend = 0; done_cnt = 0; err_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    start_valid = 1'b1; start_base_addr = b; start_count = c;
    step();
    start_valid = 1'b0;
  endtask

  // Memory model and observers: act 2 time units after each edge, for the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ncyc++;
      if (pending.size() != 0 && pending[0].due <= ncyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_word(pending[0].addr);
        void'(pending.pop_front());
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end
      case (rdy_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = ncyc[0];
        default: mem_req_ready = 1'b0;
      endcase
      if (mon_en && prev_stall) begin
        stall_seen++;
        if (!mem_req_valid || mem_req_addr !== prev_addr) stall_viol++;
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_req_addr;
      if (mem_req_valid && mem_req_ready) begin
        req_log.push_back(mem_req_addr);
        pending.push_back('{addr: mem_req_addr, due: ncyc + mem_lat});
      end
      if (pending.size() > max_pend) max_pend = pending.size();
      if (inst_valid && inst_ready && !abort && rst_n) begin
        got_pc.push_back(inst_pc);
        got_dat.push_back(inst_data);
      end
      if (done)  done_cnt++;
      if (error) err_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    steps(3);
    checks++; if (start_ready !== 1'b0)   begin errors++; $display("FAIL reset_start_ready got %b exp 0", start_ready); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (error !== 1'b0)         begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b0)    begin errors++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    checks++; if (fifo_count !== 5'd0)    begin errors++; $display("FAIL reset_fifo_count got %0d exp 0", fifo_count); end
    rst_n = 1'b1;
    step();
    checks++; if (start_ready !== 1'b1)   begin errors++; $display("FAIL post_reset_start_ready got %b exp 1", start_ready); end
    checks++; if (mem_req_write !== 1'b0 || mem_resp_ready !== 1'b1 || mem_req_data !== 32'h0)
      begin errors++; $display("FAIL tie_offs got wr=%b rr=%b wd=%h exp 0 1 0", mem_req_write, mem_resp_ready, mem_req_data); end
  endtask

  task automatic test_basic();
    clear_logs(); mem_lat = 1; rdy_mode = 0; inst_ready = 1'b1;
    do_start(32'h0, 16'd6);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", inst_valid); end
    step();
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0)
      begin errors++; $display("FAIL basic_first_inst got v=%b pc=%h exp 1 0", inst_valid, inst_pc); end
    for (int i = 0; i < 100 && !(done_cnt > 0 && got_pc.size() == 6); i++) step();
    steps(3);
    checks++; if (req_log.size() != 6) begin errors++; $display("FAIL basic_req_count got %0d exp 6", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      checks++; if (req_log[i] !== 32'(4*i)) begin errors++; $display("FAIL basic_req_addr[%0d] got %h exp %h", i, req_log[i], 32'(4*i)); end
    end
    checks++; if (got_pc.size() != 6) begin errors++; $display("FAIL basic_inst_count got %0d exp 6", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'(4*i) || got_dat[i] !== mem_word(32'(4*i)))
        begin errors++; $display("FAIL basic_inst[%0d] got pc=%h d=%h exp pc=%h d=%h", i, got_pc[i], got_dat[i], 32'(4*i), mem_word(32'(4*i))); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_cnt); end
    checks++; if (busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL basic_end_state got busy=%b cnt=%0d exp 0 0", busy, fifo_count); end
  endtask

  task automatic test_fifo_full();
    clear_logs(); mem_lat = 1; rdy_mode = 0; inst_ready = 1'b0;
    do_start(32'h100, 16'd40);
    steps(40);
    checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_fifo_count got %0d exp 16", fifo_count); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid got %b exp 0", mem_req_valid); end
    checks++; if (req_log.size() != 16) begin errors++; $display("FAIL full_req_count got %0d exp 16", req_log.size()); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== mem_word(32'h100))
      begin errors++; $display("FAIL full_head got v=%b pc=%h d=%h exp 1 100 %h", inst_valid, inst_pc, inst_data, mem_word(32'h100)); end
    inst_ready = 1'b1;
    for (int i = 0; i < 400 && !(done_cnt > 0 && got_pc.size() == 40); i++) step();
    steps(3);
    checks++; if (got_pc.size() != 40) begin errors++; $display("FAIL full_inst_count got %0d exp 40", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h100 + 32'(4*i) || got_dat[i] !== mem_word(32'h100 + 32'(4*i)))
        begin errors++; $display("FAIL full_inst[%0d] got pc=%h d=%h exp pc=%h", i, got_pc[i], got_dat[i], 32'h100 + 32'(4*i)); end
    end
    checks++; if (req_log.size() != 40) begin errors++; $display("FAIL full_total_reqs got %0d exp 40", req_log.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_stall();
    clear_logs(); mem_lat = 10; rdy_mode = 1; inst_ready = 1'b1; mon_en = 1'b1;
    do_start(32'h40, 16'd12);
    for (int i = 0; i < 500 && !(done_cnt > 0 && got_pc.size() == 12); i++) step();
    steps(3);
    mon_en = 1'b0; rdy_mode = 0; mem_lat = 1;
    checks++; if (stall_seen == 0) begin errors++; $display("FAIL stall_seen got 0 exp >0"); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stability got %0d violations exp 0", stall_viol); end
    checks++; if (max_pend != 4) begin errors++; $display("FAIL stall_max_outstanding got %0d exp 4", max_pend); end
    checks++; if (got_pc.size() != 12) begin errors++; $display("FAIL stall_inst_count got %0d exp 12", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== 32'h40 + 32'(4*i) || got_dat[i] !== mem_word(32'h40 + 32'(4*i)))
        begin errors++; $display("FAIL stall_inst[%0d] got pc=%h d=%h exp pc=%h", i, got_pc[i], got_dat[i], 32'h40 + 32'(4*i)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL stall_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_error_zero();
    clear_logs();
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL err_start_ready got %b exp 1", start_ready); end
    do_start(32'h2, 16'd5);
    checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse got err=%b busy=%b exp 1 0", error, busy); end
    step();
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", error); end
    steps(4);
    checks++; if (req_log.size() != 0 || err_cnt != 1 || done_cnt != 0)
      begin errors++; $display("FAIL err_side_effects got reqs=%0d err=%0d done=%0d exp 0 1 0", req_log.size(), err_cnt, done_cnt); end
    do_start(32'h0, 16'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got done=%b busy=%b exp 1 0", done, busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done); end
    steps(3);
    checks++; if (req_log.size() != 0 || done_cnt != 1)
      begin errors++; $display("FAIL zero_side_effects got reqs=%0d done=%0d exp 0 1", req_log.size(), done_cnt); end
  endtask

  task automatic test_abort();
    clear_logs(); mem_lat = 3; rdy_mode = 0; inst_ready = 1'b0;
    do_start(32'h300, 16'd20);
    for (int i = 0; i < 100 && fifo_count != 5'd5; i++) step();
    checks++; if (fifo_count !== 5'd5) begin errors++; $display("FAIL abort_setup_fifo got %0d exp 5", fifo_count); end
    checks++; if (pending.size() != 3 || req_log.size() != 8)
      begin errors++; $display("FAIL abort_setup_inflight got out=%0d reqs=%0d exp 3 8", pending.size(), req_log.size()); end
    checks++; if (busy !== 1'b1 || start_ready !== 1'b0)
      begin errors++; $display("FAIL abort_setup_state got busy=%b sr=%b exp 1 0", busy, start_ready); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (fifo_count !== 5'd0 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL abort_flush got cnt=%0d v=%b exp 0 0", fifo_count, inst_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_wait_busy got %b exp 1", busy); end
    steps(6);
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1)
      begin errors++; $display("FAIL abort_idle got busy=%b sr=%b exp 0 1", busy, start_ready); end
    checks++; if (fifo_count !== 5'd0 || pending.size() != 0)
      begin errors++; $display("FAIL abort_discard got cnt=%0d pend=%0d exp 0 0", fifo_count, pending.size()); end
    checks++; if (req_log.size() != 8 || done_cnt != 0)
      begin errors++; $display("FAIL abort_no_more got reqs=%0d done=%0d exp 8 0", req_log.size(), done_cnt); end
    mem_lat = 1;
  endtask

  task automatic test_wrap_reset();
    logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    clear_logs(); mem_lat = 1; rdy_mode = 0; inst_ready = 1'b1;
    do_start(32'hFFFF_FFF8, 16'd4);
    for (int i = 0; i < 100 && !(done_cnt > 0 && got_pc.size() == 4); i++) step();
    steps(2);
    checks++; if (req_log.size() != 4 || got_pc.size() != 4)
      begin errors++; $display("FAIL wrap_counts got reqs=%0d insts=%0d exp 4 4", req_log.size(), got_pc.size()); end
    for (int i = 0; i < 4 && i < req_log.size() && i < got_pc.size(); i++) begin
      checks++; if (req_log[i] !== exp_a[i] || got_pc[i] !== exp_a[i] || got_dat[i] !== mem_word(exp_a[i]))
        begin errors++; $display("FAIL wrap_addr[%0d] got req=%h pc=%h d=%h exp %h", i, req_log[i], got_pc[i], got_dat[i], exp_a[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_pulses got %0d exp 1", done_cnt); end
    clear_logs(); mem_lat = 5;
    do_start(32'h200, 16'd10);
    for (int i = 0; i < 50 && req_log.size() < 3; i++) step();
    rst_n = 1'b0;
    step();
    checks++; if (pending.size() == 0) begin errors++; $display("FAIL rst_setup_inflight got 0 exp >0"); end
    checks++; if (start_ready !== 1'b0 || busy !== 1'b0 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0 ||
                  fifo_count !== 5'd0 || done !== 1'b0 || error !== 1'b0)
      begin errors++; $display("FAIL rst_outputs got sr=%b busy=%b rv=%b iv=%b cnt=%0d done=%b err=%b exp all 0",
                               start_ready, busy, mem_req_valid, inst_valid, fifo_count, done, error); end
    step();
    rst_n = 1'b1;
    steps(8);
    checks++; if (fifo_count !== 5'd0 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL rst_late_resp got cnt=%0d v=%b exp 0 0", fifo_count, inst_valid); end
    checks++; if (busy !== 1'b0 || start_ready !== 1'b1 || pending.size() != 0 || done_cnt != 0)
      begin errors++; $display("FAIL rst_final got busy=%b sr=%b pend=%0d done=%0d exp 0 1 0 0", busy, start_ready, pending.size(), done_cnt); end
    mem_lat = 1;
  endtask

  initial begin
    rst_n = 1'b0; start_valid = 1'b0; start_base_addr = '0; start_count = '0; abort = 1'b0;
    inst_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    clear_logs();
    test_reset();
    test_basic();
    test_fifo_full();
    test_stall();
    test_error_zero();
    test_abort();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
